wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Writer-side companion of the register file.
- Merges the in-order pipeline writeback (MEM stage result) with out-of-order results from long-latency units (divider, non-blocking loads).
- Drives a single registered regfile write port: wb_write, wb_regid, wb_writedata.
- Keeps a per-register pending scoreboard and tells decode to stall on RAW/WAW hazards against outstanding long-latency writes.

Parameters:
- LL_BUF_DEPTH, 2: entries in the long-latency response buffer; power of two, >= 2.
- REG_NUM, 32: architectural register count; matches the core-wide constant.

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous active-high reset
- pipe_write  input  1  pipeline stage has a result to write
- pipe_regid  input  RF_RANGE  pipeline destination register
- pipe_writedata  input  DATA_RANGE  pipeline result
- ll_issue_valid  input  1  long-latency op issued this cycle
- ll_issue_regid  input  RF_RANGE  destination of the issued op
- ll_rsp_valid  input  1  long-latency result available
- ll_rsp_regid  input  RF_RANGE  destination of the result
- ll_rsp_data  input  DATA_RANGE  result data
- ll_rsp_ready  output  1  buffer can accept a result
- dec_rs1_regid  input  RF_RANGE  decode source 1
- dec_rs2_regid  input  RF_RANGE  decode source 2
- dec_rd_regid  input  RF_RANGE  decode destination
- dec_rd_write  input  1  decode instruction writes rd
- hazard_stall  output  1  decode must hold
- wb_write  output  1  regfile write enable
- wb_regid  output  RF_RANGE  regfile write index
- wb_writedata  output  DATA_RANGE  regfile write data

Behaviour:
- Single clock clk; rst synchronous, active-high.
- Reset values:
  - wb_write=0, wb_regid=0, wb_writedata=0.
  - Scoreboard all 0; buffer empty; ll_rsp_ready=1.
  - hazard_stall follows the combinational rules below with an empty scoreboard.
- Write port:
  - wb_* registered; one-cycle latency from the accepted source to the regfile port.
  - Per-cycle priority: pipe_write > buffer head > idle.
  - Any write with regid 0 is suppressed (wb_write=0) and never touches the scoreboard.
- LL buffer:
  - FIFO, LL_BUF_DEPTH entries of {regid, data}.
  - Result accepted on ll_rsp_valid & ll_rsp_ready; ll_rsp_ready = !full.
  - Bypass: if the buffer is empty and pipe_write=0, an accepted result goes straight to wb_* next cycle and is not stored.
  - Pop the head when it wins the port.
  - Full with a pop in the same cycle: ll_rsp_ready stays 0 that cycle (no combinational ready-from-pop path).
  - Pointers wrap modulo LL_BUF_DEPTH.
- Scoreboard (REG_NUM bits, bit 0 hard-wired 0):
  - Set: ll_issue_valid & ll_issue_regid!=0 sets the bit.
  - Clear: the bit clears on the cycle the LL result for that register is driven onto wb_* (wb_write=1, source=LL).
  - Set and clear of the same register in one cycle: set wins (newer issue).
- hazard_stall (combinational) = any of:
  - pending[rs1] & rs1!=0
  - pending[rs2] & rs2!=0
  - pending[rd] & dec_rd_write & rd!=0

  where pending[x] excludes a bit being cleared this cycle, because the regfile forwards wb_writedata to readers in the same cycle.
- Pipeline writes never target a pending register; decode stall guarantees this. Assertion flags a violation.
- Two LL results for the same register cannot both be outstanding (WAW stall). Assertion flags a violation.
- Starvation: continuous pipe_write may hold the buffer indefinitely. Acceptable, because a pending-register consumer stalls decode, which drains the pipeline.
- rst mid-operation: buffer contents and scoreboard discarded; the next cycle is idle.

Decomposition:
- RF_RANGE, DATA_RANGE and REG_NUM stay in the shared core header/package.
- Add a packed typedef wb_entry_t {regid, data} and an LL_BUF_DEPTH default there.
- One natural sub-module: wb_ll_fifo, a small synchronous FIFO with full/empty flags and no internal bypass.
- Scoreboard and arbitration stay in wb_arbiter.

Test Plan:
- Reset, then pipe_write=1, regid=5, data=0xDEAD_BEEF -> next cycle wb_write=1, wb_regid=5, wb_writedata=0xDEADBEEF; idle cycle after -> wb_write=0.
- Issue LL to x7; decode rs1=7 -> hazard_stall=1. ll_rsp regid=7, data=0x1234 with buffer empty and pipe idle -> wb_* carries x7/0x1234 next cycle, stall drops that same cycle, x7 scoreboard bit=0 after.
- pipe_write (x3) and ll_rsp (x9) in the same cycle -> x3 written first, x9 the following cycle. Buffer holds 1 entry in between; the x9 bit clears only on its write cycle.
- Three LL responses back-to-back while pipe_write=1 every cycle (DEPTH=2) -> ll_rsp_ready=0 after two accepts. Release the pipe -> entries drain in FIFO order, ready returns to 1.
- ll_issue_valid for x4 in the same cycle x4's previous LL result is written -> x4 bit remains 1 and hazard_stall persists for rs2=4.
- pipe_write or LL result to x0 -> wb_write stays 0; scoreboard unchanged; x0 never stalls. Assert rst with a buffered entry -> entry never written.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared core constants and types for the writeback arbiter and its LL buffer.
package wb_arbiter_pkg;

    localparam int unsigned CORE_REG_NUM     = 32;
    localparam int unsigned RF_W             = $clog2(CORE_REG_NUM);
    localparam int unsigned DATA_W           = 32;
    localparam int unsigned LL_BUF_DEPTH_DEF = 2;

    typedef logic [RF_W-1:0]   regid_t;
    typedef logic [DATA_W-1:0] data_t;

    typedef struct packed {
        regid_t regid;
        data_t  data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_PIPE,
        SRC_BUF,
        SRC_BYP
    } wb_src_e;

endpackage

// File: rtl/wb_ll_fifo.sv
// Small synchronous FIFO holding long-latency results awaiting the regfile port.
module wb_ll_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = LL_BUF_DEPTH_DEF
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      push_i,
    input  wb_entry_t wdata_i,
    input  logic      pop_i,
    output wb_entry_t rdata_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    wb_entry_t     mem_q [DEPTH];
    logic [PW-1:0] wr_q;
    logic [PW-1:0] rd_q;
    logic [PW:0]   cnt_q;

    // Pointers are exactly log2(DEPTH) wide, so increment wraps modulo DEPTH.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + 1'b1;
            if (pop_i)  rd_q <= rd_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_q];
    assign full_o  = (cnt_q == (PW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/wb_arbiter.sv
// Merges pipeline writeback with long-latency results onto one registered regfile
// write port and tracks outstanding long-latency destinations for decode stalls.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned LL_BUF_DEPTH = LL_BUF_DEPTH_DEF,
    parameter int unsigned REG_NUM      = CORE_REG_NUM
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   pipe_write,
    input  regid_t pipe_regid,
    input  data_t  pipe_writedata,
    input  logic   ll_issue_valid,
    input  regid_t ll_issue_regid,
    input  logic   ll_rsp_valid,
    input  regid_t ll_rsp_regid,
    input  data_t  ll_rsp_data,
    output logic   ll_rsp_ready,
    input  regid_t dec_rs1_regid,
    input  regid_t dec_rs2_regid,
    input  regid_t dec_rd_regid,
    input  logic   dec_rd_write,
    output logic   hazard_stall,
    output logic   wb_write,
    output regid_t wb_regid,
    output data_t  wb_writedata
);

    logic               wb_write_q, wb_write_d;
    logic               wb_ll_q, wb_ll_d;
    regid_t             wb_regid_q, wb_regid_d;
    data_t              wb_data_q, wb_data_d;
    logic [REG_NUM-1:0] pending_q, pending_d;
    logic [REG_NUM-1:0] pend_eff, set_vec, clr_vec;

    wb_src_e   sel;
    wb_entry_t head, rsp_entry;
    logic      fifo_full, fifo_empty, push, pop, accept;

    assign rsp_entry    = '{regid: ll_rsp_regid, data: ll_rsp_data};
    assign ll_rsp_ready = ~fifo_full;
    assign accept       = ll_rsp_valid & ~fifo_full;

    wb_ll_fifo #(.DEPTH(LL_BUF_DEPTH)) u_ll_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (push),
        .wdata_i (rsp_entry),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        sel        = SRC_NONE;
        pop        = 1'b0;
        wb_regid_d = wb_regid_q;
        wb_data_d  = wb_data_q;
        if (pipe_write) begin
            sel        = SRC_PIPE;
            wb_regid_d = pipe_regid;
            wb_data_d  = pipe_writedata;
        end else if (!fifo_empty) begin
            sel        = SRC_BUF;
            pop        = 1'b1;
            wb_regid_d = head.regid;
            wb_data_d  = head.data;
        end else if (accept) begin
            sel        = SRC_BYP;
            wb_regid_d = ll_rsp_regid;
            wb_data_d  = ll_rsp_data;
        end
        push       = accept & (sel != SRC_BYP);
        wb_write_d = (sel != SRC_NONE) & (wb_regid_d != '0);
        wb_ll_d    = wb_write_d & ((sel == SRC_BUF) | (sel == SRC_BYP));
    end

    // A pending bit clears while its LL result sits on wb_*; a same-cycle issue re-sets it.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        for (int unsigned i = 1; i < REG_NUM; i++) begin
            set_vec[i] = ll_issue_valid & (32'(ll_issue_regid) == i);
            clr_vec[i] = wb_write_q & wb_ll_q & (32'(wb_regid_q) == i);
        end
        pend_eff  = pending_q & ~clr_vec;
        pending_d = pend_eff | set_vec;
    end

    assign hazard_stall = (pend_eff[dec_rs1_regid] & (dec_rs1_regid != '0))
                        | (pend_eff[dec_rs2_regid] & (dec_rs2_regid != '0))
                        | (pend_eff[dec_rd_regid] & dec_rd_write & (dec_rd_regid != '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_write_q <= 1'b0;
            wb_ll_q    <= 1'b0;
            wb_regid_q <= '0;
            wb_data_q  <= '0;
            pending_q  <= '0;
        end else begin
            wb_write_q <= wb_write_d;
            wb_ll_q    <= wb_ll_d;
            wb_regid_q <= wb_regid_d;
            wb_data_q  <= wb_data_d;
            pending_q  <= pending_d;
        end
    end

    assign wb_write     = wb_write_q;
    assign wb_regid     = wb_regid_q;
    assign wb_writedata = wb_data_q;

    a_pipe_not_pending: assert property (@(posedge clk) disable iff (rst)
        !(pipe_write && (pipe_regid != '0) && pend_eff[pipe_regid]));

    a_no_double_issue: assert property (@(posedge clk) disable iff (rst)
        !(ll_issue_valid && (ll_issue_regid != '0) && pend_eff[ll_issue_regid]));

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: priority, bypass, buffering, scoreboard and x0 handling.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_write;
    logic [4:0]  pipe_regid;
    logic [31:0] pipe_writedata;
    logic        ll_issue_valid;
    logic [4:0]  ll_issue_regid;
    logic        ll_rsp_valid;
    logic [4:0]  ll_rsp_regid;
    logic [31:0] ll_rsp_data;
    logic        ll_rsp_ready;
    logic [4:0]  dec_rs1_regid, dec_rs2_regid, dec_rd_regid;
    logic        dec_rd_write;
    logic        hazard_stall;
    logic        wb_write;
    logic [4:0]  wb_regid;
    logic [31:0] wb_writedata;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wb_arbiter #(.LL_BUF_DEPTH(2), .REG_NUM(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .pipe_write     (pipe_write),
        .pipe_regid     (pipe_regid),
        .pipe_writedata (pipe_writedata),
        .ll_issue_valid (ll_issue_valid),
        .ll_issue_regid (ll_issue_regid),
        .ll_rsp_valid   (ll_rsp_valid),
        .ll_rsp_regid   (ll_rsp_regid),
        .ll_rsp_data    (ll_rsp_data),
        .ll_rsp_ready   (ll_rsp_ready),
        .dec_rs1_regid  (dec_rs1_regid),
        .dec_rs2_regid  (dec_rs2_regid),
        .dec_rd_regid   (dec_rd_regid),
        .dec_rd_write   (dec_rd_write),
        .hazard_stall   (hazard_stall),
        .wb_write       (wb_write),
        .wb_regid       (wb_regid),
        .wb_writedata   (wb_writedata)
    );

    task automatic idle_inputs();
        pipe_write = 1'b0; pipe_regid = '0; pipe_writedata = '0;
        ll_issue_valid = 1'b0; ll_issue_regid = '0;
        ll_rsp_valid = 1'b0; ll_rsp_regid = '0; ll_rsp_data = '0;
        dec_rs1_regid = '0; dec_rs2_regid = '0; dec_rd_regid = '0; dec_rd_write = 1'b0;
    endtask

    // Advance one edge; outputs are then sampled 1-2 time units after it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        cyc(); cyc();
        rst = 1'b0;
        dec_rs1_regid = 5'd5; dec_rs2_regid = 5'd6; dec_rd_regid = 5'd7; dec_rd_write = 1'b1;
        #1;
        n_cmp++; if (wb_write !== 1'b0) begin n_err++; $display("FAIL rst_wb_write: got %0b want 0", wb_write); end
        n_cmp++; if (wb_regid !== 5'd0) begin n_err++; $display("FAIL rst_wb_regid: got %0d want 0", wb_regid); end
        n_cmp++; if (wb_writedata !== 32'd0) begin n_err++; $display("FAIL rst_wb_data: got %h want 0", wb_writedata); end
        n_cmp++; if (ll_rsp_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %0b want 1", ll_rsp_ready); end
        n_cmp++; if (hazard_stall !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %0b want 0", hazard_stall); end
        idle_inputs();
    endtask

    task automatic test_pipe_write();
        pipe_write = 1'b1; pipe_regid = 5'd5; pipe_writedata = 32'hDEAD_BEEF;
        cyc();
        idle_inputs();
        #1;
        n_cmp++; if (wb_write !== 1'b1) begin n_err++; $display("FAIL pipe_wb_write: got %0b want 1", wb_write); end
        n_cmp++; if (wb_regid !== 5'd5) begin n_err++; $display("FAIL pipe_wb_regid: got %0d want 5", wb_regid); end
        n_cmp++; if (wb_writedata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL pipe_wb_data: got %h want deadbeef", wb_writedata); end
        cyc(); #1;
        n_cmp++; if (wb_write !== 1'b0) begin n_err++; $display("FAIL pipe_idle_after: got %0b want 0", wb_write); end
    endtask

    task automatic test_ll_bypass();
        ll_issue_valid = 1'b1; ll_issue_regid = 5'd7;
        cyc();
        idle_inputs();
        dec_rs1_regid = 5'd7;
        #1;
        n_cmp++; if (hazard_stall !== 1'b1) begin n_err++; $display("FAIL byp_stall_pending: got %0b want 1", hazard_stall); end
        ll_rsp_valid = 1'b1; ll_rsp_regid = 5'd7; ll_rsp_data = 32'h1234;
        #1;
        n_cmp++; if (ll_rsp_ready !== 1'b1) begin n_err++; $display("FAIL byp_ready: got %0b want 1", ll_rsp_ready); end
        cyc();
        ll_rsp_valid = 1'b0;
        #1;
        n_cmp++; if (wb_write !== 1'b1 || wb_regid !== 5'd7 || wb_writedata !== 32'h1234) begin
            n_err++; $display("FAIL byp_wb: got %0b/%0d/%h want 1/7/1234", wb_write, wb_regid, wb_writedata); end
        n_cmp++; if (hazard_stall !== 1'b0) begin n_err++; $display("FAIL byp_stall_clear_cycle: got %0b want 0", hazard_stall); end
        cyc(); #1;
        n_cmp++; if (hazard_stall !== 1'b0) begin n_err++; $display("FAIL byp_stall_after: got %0b want 0", hazard_stall); end
        n_cmp++; if (wb_write !== 1'b0) begin n_err++; $display("FAIL byp_idle_after: got %0b want 0", wb_write); end
        idle_inputs();
    endtask

    task automatic test_pipe_vs_ll();
        ll_issue_valid = 1'b1; ll_issue_regid = 5'd9;
        cyc();
        idle_inputs();
        pipe_write = 1'b1; pipe_regid = 5'd3; pipe_writedata = 32'h33;
        ll_rsp_valid = 1'b1; ll_rsp_regid = 5'd9; ll_rsp_data = 32'h99;
        cyc();
        idle_inputs();
        dec_rs1_regid = 5'd9;
        #1;
        n_cmp++; if (wb_write !== 1'b1 || wb_regid !== 5'd3 || wb_writedata !== 32'h33) begin
            n_err++; $display("FAIL prio_first: got %0b/%0d/%h want 1/3/33", wb_write, wb_regid, wb_writedata); end
        n_cmp++; if (hazard_stall !== 1'b1) begin n_err++; $display("FAIL prio_x9_still_pending: got %0b want 1", hazard_stall); end
        cyc(); #1;
        n_cmp++; if (wb_write !== 1'b1 || wb_regid !== 5'd9 || wb_writedata !== 32'h99) begin
            n_err++; $display("FAIL prio_second: got %0b/%0d/%h want 1/9/99", wb_write, wb_regid, wb_writedata); end
        n_cmp++; if (hazard_stall !== 1'b0) begin n_err++; $display("FAIL prio_x9_clearing: got %0b want 0", hazard_stall); end
        cyc(); #1;
        n_cmp++; if (wb_write !== 1'b0) begin n_err++; $display("FAIL prio_idle: got %0b want 0", wb_write); end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            ll_issue_valid = 1'b1; ll_issue_regid = 5'(10 + i);
            cyc();
        end
        idle_inputs();
        // A: accept x10 into empty buffer while pipe holds the port
        pipe_write = 1'b1; pipe_regid = 5'd20; pipe_writedata = 32'h20;
        ll_rsp_valid = 1'b1; ll_rsp_regid = 5'd10; ll_rsp_data = 32'hA0;
        #1;
        n_cmp++; if (ll_rsp_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_a: got %0b want 1", ll_rsp_ready); end
        cyc();
        pipe_regid = 5'd21; pipe_writedata = 32'h21;
        ll_rsp_regid = 5'd11; ll_rsp_data = 32'hA1;
        #1;
        n_cmp++; if (ll_rsp_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_b: got %0b want 1", ll_rsp_ready); end
        cyc();
        pipe_regid = 5'd22; pipe_writedata = 32'h22;
        ll_rsp_regid = 5'd12; ll_rsp_data = 32'hA2;
        #1;
        n_cmp++; if (ll_rsp_ready !== 1'b0) begin n_err++; $display("FAIL b2b_full: got %0b want 0", ll_rsp_ready); end
        n_cmp++; if (wb_regid !== 5'd21 || wb_write !== 1'b1) begin n_err++; $display("FAIL b2b_pipe21: got %0b/%0d want 1/21", wb_write, wb_regid); end
        cyc();
        pipe_regid = 5'd23; pipe_writedata = 32'h23;
        #1;
        n_cmp++; if (ll_rsp_ready !== 1'b0) begin n_err++; $display("FAIL b2b_full_hold: got %0b want 0", ll_rsp_ready); end
        cyc();
        pipe_write = 1'b0;
        #1;
        n_cmp++; if (ll_rsp_ready !== 1'b0) begin n_err++; $display("FAIL b2b_full_pop_same_cycle: got %0b want 0", ll_rsp_ready); end
        n_cmp++; if (wb_regid !== 5'd23) begin n_err++; $display("FAIL b2b_pipe23: got %0d want 23", wb_regid); end
        cyc();
        #1;
        n_cmp++; if (wb_write !== 1'b1 || wb_regid !== 5'd10 || wb_writedata !== 32'hA0) begin
            n_err++; $display("FAIL b2b_drain0: got %0b/%0d/%h want 1/10/a0", wb_write, wb_regid, wb_writedata); end
        n_cmp++; if (ll_rsp_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_back: got %0b want 1", ll_rsp_ready); end
        cyc();
        ll_rsp_valid = 1'b0;
        #1;
        n_cmp++; if (wb_write !== 1'b1 || wb_regid !== 5'd11 || wb_writedata !== 32'hA1) begin
            n_err++; $display("FAIL b2b_drain1: got %0b/%0d/%h want 1/11/a1", wb_write, wb_regid, wb_writedata); end
        cyc(); #1;
        n_cmp++; if (wb_write !== 1'b1 || wb_regid !== 5'd12 || wb_writedata !== 32'hA2) begin
            n_err++; $display("FAIL b2b_drain2: got %0b/%0d/%h want 1/12/a2", wb_write, wb_regid, wb_writedata); end
        cyc(); #1;
        n_cmp++; if (wb_write !== 1'b0 || ll_rsp_ready !== 1'b1) begin
            n_err++; $display("FAIL b2b_empty: got write %0b ready %0b want 0/1", wb_write, ll_rsp_ready); end
        idle_inputs();
    endtask

    task automatic test_set_clear_same();
        ll_issue_valid = 1'b1; ll_issue_regid = 5'd4;
        cyc();
        idle_inputs();
        ll_rsp_valid = 1'b1; ll_rsp_regid = 5'd4; ll_rsp_data = 32'h44;
        cyc();
        idle_inputs();
        ll_issue_valid = 1'b1; ll_issue_regid = 5'd4;
        dec_rs2_regid = 5'd4;
        #1;
        n_cmp++; if (wb_write !== 1'b1 || wb_regid !== 5'd4) begin n_err++; $display("FAIL sc_wb_x4: got %0b/%0d want 1/4", wb_write, wb_regid); end
        n_cmp++; if (hazard_stall !== 1'b0) begin n_err++; $display("FAIL sc_stall_forward: got %0b want 0", hazard_stall); end
        cyc();
        ll_issue_valid = 1'b0;
        #1;
        n_cmp++; if (hazard_stall !== 1'b1) begin n_err++; $display("FAIL sc_set_wins: got %0b want 1", hazard_stall); end
        cyc(); #1;
        n_cmp++; if (hazard_stall !== 1'b1) begin n_err++; $display("FAIL sc_still_pending: got %0b want 1", hazard_stall); end
        ll_rsp_valid = 1'b1; ll_rsp_regid = 5'd4; ll_rsp_data = 32'h45;
        cyc();
        ll_rsp_valid = 1'b0;
        cyc(); #1;
        n_cmp++; if (hazard_stall !== 1'b0) begin n_err++; $display("FAIL sc_final_clear: got %0b want 0", hazard_stall); end
        idle_inputs();
    endtask

    task automatic test_x0();
        ll_issue_valid = 1'b1; ll_issue_regid = 5'd8;
        cyc();
        idle_inputs();
        pipe_write = 1'b1; pipe_regid = 5'd0; pipe_writedata = 32'hFF;
        cyc();
        pipe_write = 1'b0;
        #1;
        n_cmp++; if (wb_write !== 1'b0) begin n_err++; $display("FAIL x0_pipe: got %0b want 0", wb_write); end
        ll_rsp_valid = 1'b1; ll_rsp_regid = 5'd0; ll_rsp_data = 32'hEE;
        ll_issue_valid = 1'b1; ll_issue_regid = 5'd0;
        cyc();
        idle_inputs();
        dec_rs1_regid = 5'd0; dec_rs2_regid = 5'd0; dec_rd_regid = 5'd0; dec_rd_write = 1'b1;
        #1;
        n_cmp++; if (wb_write !== 1'b0) begin n_err++; $display("FAIL x0_ll: got %0b want 0", wb_write); end
        n_cmp++; if (hazard_stall !== 1'b0) begin n_err++; $display("FAIL x0_stall: got %0b want 0", hazard_stall); end
        dec_rd_regid = 5'd8;
        #1;
        n_cmp++; if (hazard_stall !== 1'b1) begin n_err++; $display("FAIL x0_sb_unchanged: got %0b want 1", hazard_stall); end
        ll_rsp_valid = 1'b1; ll_rsp_regid = 5'd8; ll_rsp_data = 32'h88;
        dec_rd_write = 1'b0;
        cyc();
        idle_inputs();
        cyc();
    endtask

    task automatic test_reset_mid();
        ll_issue_valid = 1'b1; ll_issue_regid = 5'd15;
        cyc();
        idle_inputs();
        pipe_write = 1'b1; pipe_regid = 5'd16; pipe_writedata = 32'h16;
        ll_rsp_valid = 1'b1; ll_rsp_regid = 5'd15; ll_rsp_data = 32'h15;
        cyc();
        idle_inputs();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        dec_rs1_regid = 5'd15;
        #1;
        n_cmp++; if (wb_write !== 1'b0) begin n_err++; $display("FAIL rmid_idle: got %0b want 0", wb_write); end
        n_cmp++; if (hazard_stall !== 1'b0) begin n_err++; $display("FAIL rmid_sb_cleared: got %0b want 0", hazard_stall); end
        cyc(); #1;
        n_cmp++; if (wb_write !== 1'b0) begin n_err++; $display("FAIL rmid_entry_dropped: got %0b/%0d want 0", wb_write, wb_regid); end
        n_cmp++; if (ll_rsp_ready !== 1'b1) begin n_err++; $display("FAIL rmid_ready: got %0b want 1", ll_rsp_ready); end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_pipe_write();
        test_ll_bypass();
        test_pipe_vs_ll();
        test_back_to_back();
        test_set_clear_same();
        test_x0();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

endmodule
